// File: rtl/updown_sweep_ctrl_if.sv
// Control/feedback bundle between the triangle-sweep sequencer and the
// saturating up/down counter it drives.
interface updown_sweep_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             abort;
    logic [3:0]       n_sweeps;
    logic [WIDTH-1:0] count_in;
    logic             cnt_reset;
    logic             cnt_up_down;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             err;
    logic [3:0]       sweep_idx;

    modport master (
        output start, abort, n_sweeps, count_in,
        input  cnt_reset, cnt_up_down, busy, done, aborted, err, sweep_idx
    );

    modport slave (
        input  start, abort, n_sweeps, count_in,
        output cnt_reset, cnt_up_down, busy, done, aborted, err, sweep_idx
    );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Runs N triangle sweeps (0 -> MAX -> 0) on a saturating up/down counter with
// dwell at both ends, mirroring the expected count and flagging divergence.
module updown_sweep_ctrl #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned HOLD_TOP = 2,
    parameter int unsigned HOLD_BOT = 2
) (
    input logic                clk,
    input logic                reset,
    updown_sweep_ctrl_if.slave bus
);
    localparam int unsigned      HW          = 8;
    localparam logic [WIDTH-1:0] MAX         = {WIDTH{1'b1}};
    localparam logic [HW-1:0]    HOLD_T_LAST = HW'(HOLD_TOP - 1);
    localparam logic [HW-1:0]    HOLD_B_LAST = HW'(HOLD_BOT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_UP, S_HOLD_T, S_DOWN, S_HOLD_B, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [3:0]       sweep_q, sweep_d;
    logic [3:0]       n_q, n_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             err_q, err_d;
    logic             cnt_reset_q, cnt_reset_d;
    logic             up_down_q, up_down_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             in_run;
    logic             mismatch;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            sweep_q     <= '0;
            n_q         <= '0;
            exp_q       <= '0;
            err_q       <= 1'b0;
            cnt_reset_q <= 1'b1;
            up_down_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            sweep_q     <= sweep_d;
            n_q         <= n_d;
            exp_q       <= exp_d;
            err_q       <= err_d;
            cnt_reset_q <= cnt_reset_d;
            up_down_q   <= up_down_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    // Next state, sweep bookkeeping and counter mirror
    always_comb begin
        state_d   = state_q;
        hold_d    = '0;
        sweep_d   = sweep_q;
        n_d       = n_q;
        err_d     = err_q;
        aborted_d = 1'b0;
        in_run    = (state_q == S_UP) || (state_q == S_HOLD_T) ||
                    (state_q == S_DOWN) || (state_q == S_HOLD_B);
        mismatch  = in_run && (bus.count_in != exp_q);

        // Mirror follows what the counter sees: our registered controls
        if (cnt_reset_q)
            exp_d = '0;
        else if (up_down_q)
            exp_d = (exp_q == MAX) ? MAX : exp_q + WIDTH'(1);
        else
            exp_d = (exp_q == '0) ? '0 : exp_q - WIDTH'(1);

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort && (bus.n_sweeps != 4'd0)) begin
                    state_d = S_UP;
                    n_d     = bus.n_sweeps;
                    err_d   = 1'b0;
                    sweep_d = '0;
                end
            end
            S_UP: begin
                if (bus.count_in == MAX) state_d = S_HOLD_T;
            end
            S_HOLD_T: begin
                if (hold_q == HOLD_T_LAST) state_d = S_DOWN;
                else                       hold_d  = hold_q + HW'(1);
            end
            S_DOWN: begin
                if (bus.count_in == '0) state_d = S_HOLD_B;
            end
            S_HOLD_B: begin
                if (hold_q == HOLD_B_LAST) begin
                    if (sweep_q == 4'(n_q - 4'd1)) begin
                        state_d = S_DONE;
                    end else begin
                        sweep_d = 4'(sweep_q + 4'd1);
                        state_d = S_UP;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort or divergence wins over any same-cycle sweep progress
        if (in_run && (bus.abort || mismatch)) begin
            state_d   = S_IDLE;
            hold_d    = '0;
            sweep_d   = sweep_q;
            aborted_d = 1'b1;
            if (mismatch) err_d = 1'b1;
        end
    end

    // Moore outputs decoded from the upcoming state
    always_comb begin
        cnt_reset_d = 1'b1;
        up_down_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            S_UP, S_HOLD_T: begin
                cnt_reset_d = 1'b0;
                up_down_d   = 1'b1;
                busy_d      = 1'b1;
            end
            S_DOWN, S_HOLD_B: begin
                cnt_reset_d = 1'b0;
                busy_d      = 1'b1;
            end
            S_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.cnt_reset   = cnt_reset_q;
    assign bus.cnt_up_down = up_down_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.aborted     = aborted_q;
    assign bus.err         = err_q;
    assign bus.sweep_idx   = sweep_q;
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: a saturating counter closes the loop, and a
// run-position model predicts every output each cycle.
module tb_updown_sweep_ctrl;
    localparam int unsigned WIDTH = 4;
    localparam int MAXV = 15;
    localparam int HT   = 2;
    localparam int HB   = 2;
    localparam int PER  = 2 * (MAXV + 1) + HT + HB;
    localparam int UP_PH = MAXV + 1 + HT;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    updown_sweep_ctrl_if #(.WIDTH(WIDTH)) bus ();

    updown_sweep_ctrl #(.WIDTH(WIDTH), .HOLD_TOP(HT), .HOLD_BOT(HB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Counter being sequenced, with an optional forced value on its output
    logic [3:0] cnt = 4'd0;
    logic       inj = 1'b0;
    logic [3:0] inj_val = 4'd0;
    always @(posedge clk) begin
        if (bus.cnt_reset)        cnt <= 4'd0;
        else if (bus.cnt_up_down) cnt <= (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;
        else                      cnt <= (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    end
    assign bus.count_in = inj ? inj_val : cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Expected count at position p within one sweep
    function automatic int exp_count(input int p);
        if (p <= MAXV) return p;
        if (p < MAXV + 1 + HT) return MAXV;
        if (p < 2 * (MAXV + 1) + HT) return 2 * MAXV + 1 + HT - p;
        return 0;
    endfunction

    // Model: a run is a position t over n*PER busy cycles
    bit m_run = 0, m_in_done = 0, m_err = 0, m_abt = 0;
    int m_t = 0, m_n = 0, m_sweep = 0;
    always @(posedge clk) begin
        bit mm;
        if (!reset) begin
            m_run = 0; m_in_done = 0; m_err = 0; m_abt = 0;
            m_t = 0; m_n = 0; m_sweep = 0;
        end else begin
            m_abt = 0;
            if (m_run) begin
                mm = (int'(bus.count_in) != exp_count(m_t % PER));
                if (bus.abort || mm) begin
                    m_run = 0; m_abt = 1;
                    if (mm) m_err = 1;
                end else if (m_t == PER * m_n - 1) begin
                    m_run = 0; m_in_done = 1;
                end else begin
                    m_t++;
                    m_sweep = m_t / PER;
                end
            end else if (m_in_done) begin
                m_in_done = 0;
            end else if (bus.start && !bus.abort && bus.n_sweeps != 4'd0) begin
                m_run = 1; m_t = 0; m_n = int'(bus.n_sweeps); m_err = 0; m_sweep = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("busy",      32'(bus.busy),        32'(m_run));
            chk("done",      32'(bus.done),        32'(m_in_done));
            chk("aborted",   32'(bus.aborted),     32'(m_abt));
            chk("err",       32'(bus.err),         32'(m_err));
            chk("cnt_reset", 32'(bus.cnt_reset),   32'(!m_run));
            chk("up_down",   32'(bus.cnt_up_down), 32'(m_run && ((m_t % PER) < UP_PH)));
            chk("sweep_idx", 32'(bus.sweep_idx),   32'(m_sweep));
        end
    end

    // Activity counters for the directed scenarios
    int busy_cnt = 0, done_cnt = 0, abt_cnt = 0, max_idx = 0, tr_n = 0;
    int trace [0:127];
    always @(posedge clk) begin
        #2;
        if (bus.busy) begin
            busy_cnt++;
            if (tr_n < 128) begin
                trace[tr_n] = int'(bus.count_in);
                tr_n++;
            end
        end
        if (bus.done) done_cnt++;
        if (bus.aborted) abt_cnt++;
        if (int'(bus.sweep_idx) > max_idx) max_idx = int'(bus.sweep_idx);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the first run cycle
    task automatic start_pulse(input logic [3:0] n);
        tr_n = 0; busy_cnt = 0; done_cnt = 0; abt_cnt = 0; max_idx = 0;
        bus.start = 1'b1;
        bus.n_sweeps = n;
        @(negedge clk);
        bus.start = 1'b0;
        bus.n_sweeps = 4'($urandom);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.n_sweeps = 4'd0;
        @(negedge clk);
        chk_en = 1'b1;
        wait_cyc(2);
        chk("rst_cnt_reset", 32'(bus.cnt_reset), 32'd1);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        chk("rst_sweep_idx", 32'(bus.sweep_idx), 32'd0);
        reset = 1'b1;
        wait_cyc(3);

        // One sweep
        start_pulse(4'd1);
        wait_cyc(40);
        chk("s1_busy_cycles", 32'(busy_cnt), 32'd36);
        chk("s1_done_pulses", 32'(done_cnt), 32'd1);
        chk("s1_aborts",      32'(abt_cnt),  32'd0);
        chk("s1_err",         32'(bus.err),  32'd0);
        chk("s1_tr0",  32'(trace[0]),  32'd0);
        chk("s1_tr15", 32'(trace[15]), 32'd15);
        chk("s1_tr17", 32'(trace[17]), 32'd15);
        chk("s1_tr18", 32'(trace[18]), 32'd15);
        chk("s1_tr19", 32'(trace[19]), 32'd14);
        chk("s1_tr33", 32'(trace[33]), 32'd0);
        chk("s1_tr35", 32'(trace[35]), 32'd0);

        // Three sweeps
        start_pulse(4'd3);
        wait_cyc(115);
        chk("s3_busy_cycles", 32'(busy_cnt),      32'd108);
        chk("s3_done_pulses", 32'(done_cnt),      32'd1);
        chk("s3_max_idx",     32'(max_idx),       32'd2);
        chk("s3_sweep_idx",   32'(bus.sweep_idx), 32'd2);

        // Zero sweeps requested
        start_pulse(4'd0);
        wait_cyc(5);
        chk("n0_busy_cycles", 32'(busy_cnt), 32'd0);
        chk("n0_done_pulses", 32'(done_cnt), 32'd0);

        // Start while busy is ignored
        start_pulse(4'd1);
        wait_cyc(10);
        bus.start = 1'b1; bus.n_sweeps = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_cyc(40);
        chk("sb_busy_cycles", 32'(busy_cnt), 32'd36);
        chk("sb_done_pulses", 32'(done_cnt), 32'd1);

        // Abort together with start in IDLE
        busy_cnt = 0;
        bus.start = 1'b1; bus.abort = 1'b1; bus.n_sweeps = 4'd2;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        wait_cyc(3);
        chk("as_busy_cycles", 32'(busy_cnt), 32'd0);

        // Abort on the 5th DOWN cycle
        start_pulse(4'd1);
        wait_cyc(22);
        chk("ab_count_in", 32'(bus.count_in),    32'd11);
        chk("ab_up_down",  32'(bus.cnt_up_down), 32'd0);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("ab_aborted",   32'(bus.aborted),   32'd1);
        chk("ab_cnt_reset", 32'(bus.cnt_reset), 32'd1);
        chk("ab_busy",      32'(bus.busy),      32'd0);
        wait_cyc(5);
        chk("ab_done_pulses", 32'(done_cnt), 32'd0);
        chk("ab_busy_cycles", 32'(busy_cnt), 32'd23);

        // Forced 7 where 6 is expected
        start_pulse(4'd1);
        wait_cyc(6);
        chk("mm_count_in", 32'(bus.count_in), 32'd6);
        inj = 1'b1; inj_val = 4'd7;
        @(negedge clk);
        inj = 1'b0;
        chk("mm_err",     32'(bus.err),     32'd1);
        chk("mm_aborted", 32'(bus.aborted), 32'd1);
        chk("mm_busy",    32'(bus.busy),    32'd0);
        wait_cyc(3);
        start_pulse(4'd1);
        chk("mm_err_clear", 32'(bus.err), 32'd0);
        wait_cyc(40);
        chk("mm_done_pulses", 32'(done_cnt), 32'd1);

        // Reset during top dwell
        start_pulse(4'd2);
        wait_cyc(16);
        chk("rh_up_down",  32'(bus.cnt_up_down), 32'd1);
        chk("rh_count_in", 32'(bus.count_in),    32'd15);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rh_cnt_reset", 32'(bus.cnt_reset),   32'd1);
        chk("rh_up_down0",  32'(bus.cnt_up_down), 32'd0);
        chk("rh_busy",      32'(bus.busy),        32'd0);
        chk("rh_sweep_idx", 32'(bus.sweep_idx),   32'd0);
        wait_cyc(5);
        chk("rh_done_pulses",  32'(done_cnt), 32'd0);
        chk("rh_abort_pulses", 32'(abt_cnt),  32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 8000; c++) begin
            reset        = ($urandom_range(1499) != 0);
            bus.start    = ($urandom_range(19) == 0);
            bus.abort    = ($urandom_range(299) == 0);
            bus.n_sweeps = ($urandom_range(9) == 0) ? 4'd15 : 4'($urandom_range(3));
            inj          = bus.busy && ($urandom_range(499) == 0);
            inj_val      = 4'(cnt + 4'($urandom_range(15, 1)));
            @(negedge clk);
        end
        reset = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; inj = 1'b0;
        wait_cyc(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
